// File: rtl/pig_status_tracker.sv
// rtl/pig_status_tracker.sv - per-level pig population, frame-boundary kills, level-clear pulse and score
module pig_status_tracker #(
    parameter int                  NUM_PIGS       = 4,
    parameter int                  NUM_LEVELS     = 2,
    parameter logic [NUM_PIGS-1:0] LEVEL0_MASK    = 4'b0011,
    parameter logic [NUM_PIGS-1:0] LEVEL1_MASK    = 4'b1111,
    parameter logic [NUM_PIGS-1:0] LEVEL2_MASK    = 4'b1111,
    parameter logic [NUM_PIGS-1:0] LEVEL3_MASK    = 4'b1111,
    parameter logic [15:0]         POINTS_PER_PIG = 16'd100
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                drawing_request_bird,
    input  logic [NUM_PIGS-1:0] drawing_request_pigs,
    input  logic [3:0]          current_level,
    input  logic                game_over,
    output logic                pigs_left,
    output logic [NUM_PIGS-1:0] pigs_alive,
    output logic [3:0]          pigs_count,
    output logic                pig_killed,
    output logic [15:0]         score
);
    typedef enum logic [2:0] {
        S_LOAD, S_PLAY, S_CLEARED, S_WAIT_LEVEL, S_FINISHED
    } state_t;

    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS);

    state_t              state_q, state_d;
    logic [3:0]          lvl_q, lvl_d;
    logic [NUM_PIGS-1:0] alive_q, alive_d;
    logic [NUM_PIGS-1:0] pending_q, pending_d;
    logic [15:0]         score_q, score_d;
    logic                killed_q, killed_d;
    logic [NUM_PIGS-1:0] hits;
    logic [31:0]         sum;

    function automatic logic [3:0] popcnt(input logic [NUM_PIGS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_PIGS; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    function automatic logic [NUM_PIGS-1:0] level_mask(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return LEVEL0_MASK;
            2'd1:    return LEVEL1_MASK;
            2'd2:    return LEVEL2_MASK;
            default: return LEVEL3_MASK;
        endcase
    endfunction

    assign hits = drawing_request_pigs & {NUM_PIGS{drawing_request_bird}} & alive_q;
    assign sum  = 32'(score_q) + 32'(popcnt(pending_q)) * 32'(POINTS_PER_PIG);

    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        alive_d   = alive_q;
        pending_d = pending_q;
        score_d   = score_q;
        killed_d  = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                lvl_d     = current_level;
                pending_d = '0;
                if (current_level < LAST_LEVEL) begin
                    alive_d = level_mask(current_level[1:0]);
                    state_d = S_PLAY;
                end else begin
                    alive_d = '0;
                    state_d = S_FINISHED;
                end
            end
            S_PLAY: begin
                if (startOfFrame) begin
                    // Hits on the boundary clk start the next frame's set; pigs dying now are excluded.
                    alive_d   = alive_q & ~pending_q;
                    pending_d = hits & ~pending_q;
                    if (pending_q != '0) begin
                        killed_d = 1'b1;
                        score_d  = (sum > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
                    end
                end else begin
                    pending_d = pending_q | hits;
                end
                if (alive_q == '0 && pending_q == '0) state_d = S_CLEARED;
            end
            S_CLEARED: begin
                pending_d = '0;
                state_d   = S_WAIT_LEVEL;
            end
            S_WAIT_LEVEL: begin
                pending_d = '0;
                if (current_level != lvl_q) state_d = S_LOAD;
            end
            S_FINISHED: begin
                alive_d   = '0;
                pending_d = '0;
            end
            default: state_d = S_LOAD;
        endcase
        // game_over wins over every transition and discards any pending kill.
        if (game_over) begin
            state_d   = S_FINISHED;
            alive_d   = '0;
            pending_d = '0;
            score_d   = score_q;
            killed_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_LOAD;
            lvl_q     <= '0;
            alive_q   <= '0;
            pending_q <= '0;
            score_q   <= '0;
            killed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            alive_q   <= alive_d;
            pending_q <= pending_d;
            score_q   <= score_d;
            killed_q  <= killed_d;
        end
    end

    assign pigs_left  = (state_q != S_CLEARED);
    assign pigs_alive = alive_q;
    assign pigs_count = popcnt(alive_q);
    assign pig_killed = killed_q;
    assign score      = score_q;
endmodule

// File: tb/tb_pig_status_tracker.sv
// tb/tb_pig_status_tracker.sv - scoreboard bench for pig_status_tracker with a model level controller
module tb_pig_status_tracker;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        drawing_request_bird = 1'b0;
    logic [3:0]  drawing_request_pigs = '0;
    logic [3:0]  current_level = '0;
    logic        game_over = 1'b0;
    logic        pigs_left;
    logic [3:0]  pigs_alive;
    logic [3:0]  pigs_count;
    logic        pig_killed;
    logic [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;
    logic prev_low = 1'b0;

    typedef struct {
        logic [3:0]  alive;
        logic [15:0] score;
    } kill_t;

    kill_t      kill_q[$];
    logic [3:0] clr_q[$];

    pig_status_tracker dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .drawing_request_bird (drawing_request_bird),
        .drawing_request_pigs (drawing_request_pigs),
        .current_level        (current_level),
        .game_over            (game_over),
        .pigs_left            (pigs_left),
        .pigs_alive           (pigs_alive),
        .pigs_count           (pigs_count),
        .pig_killed           (pig_killed),
        .score                (score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor plus model controller: one level++ per observed low pigs_left clk.
    always @(negedge clk) begin
        if (!resetN) begin
            current_level = '0;
            prev_low      = 1'b0;
        end else begin
            if (pig_killed) begin
                if (kill_q.size() == 0) begin
                    check("kill_unexpected", 32'd1, 32'd0);
                end else begin
                    kill_t k;
                    k = kill_q.pop_front();
                    check("kill_alive", 32'(pigs_alive), 32'(k.alive));
                    check("kill_score", 32'(score), 32'(k.score));
                end
            end
            if (!pigs_left) begin
                check("pigs_left_pulse_width", 32'(prev_low), 32'd0);
                if (clr_q.size() == 0) begin
                    check("clear_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [3:0] l;
                    l = clr_q.pop_front();
                    check("clear_level", 32'(current_level), 32'(l));
                end
                current_level = current_level + 4'd1;
            end
            prev_low = !pigs_left;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hit(input logic [3:0] m, input int n);
        drawing_request_bird = 1'b1;
        drawing_request_pigs = m;
        tick(n);
        drawing_request_bird = 1'b0;
        drawing_request_pigs = '0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
    endtask

    initial begin
        tick(1);
        check("rst_alive", 32'(pigs_alive), 32'h0);
        check("rst_count", 32'(pigs_count), 32'd0);
        check("rst_left", 32'(pigs_left), 32'd1);
        check("rst_killed", 32'(pig_killed), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        resetN = 1'b1;
        tick(2);
        // T1: level 0 loaded
        check("t1_alive", 32'(pigs_alive), 32'h3);
        check("t1_count", 32'(pigs_count), 32'd2);
        check("t1_left", 32'(pigs_left), 32'd1);
        check("t1_score", 32'(score), 32'd0);
        // T2: long overlap on pig0, one kill at the frame boundary
        hit(4'b0001, 30);
        tick(2);
        check("t2_alive_before_sof", 32'(pigs_alive), 32'h3);
        kill_q.push_back('{alive: 4'b0010, score: 16'd100});
        sof();
        tick(3);
        check("t2_count", 32'(pigs_count), 32'd1);
        // T3: hit on live pig1 and dead pig0, level clears
        hit(4'b0011, 10);
        kill_q.push_back('{alive: 4'b0000, score: 16'd200});
        clr_q.push_back(4'd0);
        sof();
        tick(8);
        // T4: level 1 loaded after exactly one increment
        check("t4_level", 32'(current_level), 32'd1);
        check("t4_alive", 32'(pigs_alive), 32'hF);
        check("t4_count", 32'(pigs_count), 32'd4);
        tick(5);
        check("t4_no_double_inc", 32'(current_level), 32'd1);
        // T5: hit coincident with SOF is deferred to the next boundary
        startOfFrame = 1'b1;
        drawing_request_bird = 1'b1;
        drawing_request_pigs = 4'b0100;
        tick(1);
        startOfFrame = 1'b0;
        drawing_request_bird = 1'b0;
        drawing_request_pigs = '0;
        tick(3);
        check("t5_alive_deferred", 32'(pigs_alive), 32'hF);
        kill_q.push_back('{alive: 4'b1011, score: 16'd300});
        sof();
        tick(3);
        check("t5_count", 32'(pigs_count), 32'd3);
        // T6: clear level 1, multi-pig kill, then level 2 means finished
        hit(4'b1011, 5);
        kill_q.push_back('{alive: 4'b0000, score: 16'd600});
        clr_q.push_back(4'd1);
        sof();
        tick(10);
        check("t6_level", 32'(current_level), 32'd2);
        check("t6_alive", 32'(pigs_alive), 32'h0);
        check("t6_left", 32'(pigs_left), 32'd1);
        hit(4'b1111, 4);
        sof();
        tick(3);
        check("t6_finished_score", 32'(score), 32'd600);
        check("t6_finished_alive", 32'(pigs_alive), 32'h0);
        // Asynchronous reset mid-operation
        #2 resetN = 1'b0;
        #1;
        check("arst_score", 32'(score), 32'd0);
        check("arst_alive", 32'(pigs_alive), 32'h0);
        check("arst_left", 32'(pigs_left), 32'd1);
        tick(2);
        resetN = 1'b1;
        tick(2);
        check("rerun_alive", 32'(pigs_alive), 32'h3);
        // game_over with a pending hit: nothing killed, score frozen
        hit(4'b0001, 5);
        game_over = 1'b1;
        tick(1);
        sof();
        tick(4);
        check("go_score", 32'(score), 32'd0);
        check("go_alive", 32'(pigs_alive), 32'h0);
        check("go_left", 32'(pigs_left), 32'd1);
        check("kill_queue_drained", 32'(kill_q.size()), 32'd0);
        check("clear_queue_drained", 32'(clr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
